// File: rtl/core_sequencer_if.sv
// Purpose: bundles the scheduler-side handshake and the core datapath controls of core_sequencer.
// Latency: none; this is wiring only.
// Backpressure: none; start is a level sampled by the sequencer only while it is idle.
// Ports: start/first/last/tweak come from the block scheduler; busy/done go back to it;
//        all remaining signals drive the Threefish-1024 core datapath.
// master = sequencer side, slave = scheduler/core side.
interface core_sequencer_if;
    logic         start_i;
    logic         first_block_i;
    logic         last_block_i;
    logic [127:0] tweak_i;
    logic         busy_o;
    logic         done_o;
    logic         input_register_write_o;
    logic [3:0]   word_o;
    logic         x0_key_select_o;
    logic [1:0]   x1_tweak_subkey_select_o;
    logic [63:0]  tweak_word_o;
    logic [7:0]   rotate_constant_o;
    logic [15:0]  Y1_select_o;
    logic [15:0]  output_register_write_o;
    logic         key_register_write_o;
    logic         hash_mode_o;
    logic         subkey_write_o;
    logic         output_register_plaintext_select_o;
    logic [4:0]   subkey_o;
    logic         hash_register_write_o;

    modport master (
        input  start_i, first_block_i, last_block_i, tweak_i,
        output busy_o, done_o, input_register_write_o, word_o, x0_key_select_o,
               x1_tweak_subkey_select_o, tweak_word_o, rotate_constant_o, Y1_select_o,
               output_register_write_o, key_register_write_o, hash_mode_o, subkey_write_o,
               output_register_plaintext_select_o, subkey_o, hash_register_write_o
    );

    modport slave (
        output start_i, first_block_i, last_block_i, tweak_i,
        input  busy_o, done_o, input_register_write_o, word_o, x0_key_select_o,
               x1_tweak_subkey_select_o, tweak_word_o, rotate_constant_o, Y1_select_o,
               output_register_write_o, key_register_write_o, hash_mode_o, subkey_write_o,
               output_register_plaintext_select_o, subkey_o, hash_register_write_o
    );
endinterface

// File: rtl/core_sequencer.sv
// Purpose: FSM driving the Skein-1024/Threefish-1024 core through one block (load, 21 injections, 80 rounds, feed-forward).
// Latency: start accepted at cycle 0 -> done pulse at cycle 1078, idle again at cycle 1079.
// Backpressure: none; start is ignored while busy, a block cannot be stalled once launched.
// Ports: clk_i, rst_i (synchronous, active high); bus (core_sequencer_if.master) carries
//        the scheduler handshake and every core control.
module core_sequencer #(
    parameter int ROUNDS     = 80,
    parameter int INJ_PERIOD = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    core_sequencer_if.master   bus
);
    localparam int NUM_INJ = ROUNDS / INJ_PERIOD;
    localparam int RW      = $clog2(ROUNDS + 1);

    // Threefish-1024 rotation constants, indexed {round mod 8, pair}.
    localparam logic [7:0] ROT [64] = '{
        8'd24, 8'd13, 8'd8,  8'd47, 8'd8,  8'd17, 8'd22, 8'd37,
        8'd38, 8'd19, 8'd10, 8'd55, 8'd49, 8'd18, 8'd23, 8'd52,
        8'd33, 8'd4,  8'd51, 8'd13, 8'd34, 8'd41, 8'd59, 8'd17,
        8'd5,  8'd20, 8'd48, 8'd41, 8'd47, 8'd28, 8'd16, 8'd25,
        8'd41, 8'd9,  8'd37, 8'd31, 8'd12, 8'd47, 8'd44, 8'd30,
        8'd16, 8'd34, 8'd56, 8'd51, 8'd4,  8'd53, 8'd42, 8'd41,
        8'd31, 8'd44, 8'd47, 8'd46, 8'd19, 8'd42, 8'd44, 8'd25,
        8'd9,  8'd48, 8'd35, 8'd52, 8'd23, 8'd31, 8'd37, 8'd20
    };

    typedef enum logic [2:0] {IDLE, LOAD, INJECT, COPY_K, MIX, COPY_R, FINAL} state_t;

    state_t          state, state_nxt, cur;
    logic [4:0]      s;
    logic [RW-1:0]   r;
    logic [3:0]      w;
    logic            first_q, last_q;
    logic [63:0]     t0_q, t1_q, t2;
    logic [RW-1:0]   r_inc;
    logic [1:0]      s_mod3;
    logic [63:0]     tw_a, tw_b;

    assign t2     = t0_q ^ t1_q;
    assign r_inc  = r + RW'(1);
    assign s_mod3 = 2'(s % 5'd3);

    // Reset forces the output decode to IDLE so nothing (least of all a write
    // enable) is asserted in the reset cycle, even when reset lands mid-block.
    assign cur = rst_i ? IDLE : state;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            s       <= '0;
            r       <= '0;
            w       <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            t0_q    <= '0;
            t1_q    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (bus.start_i) begin
                    first_q <= bus.first_block_i;
                    last_q  <= bus.last_block_i;
                    t0_q    <= bus.tweak_i[63:0];
                    t1_q    <= bus.tweak_i[127:64];
                end
                LOAD: begin
                    s <= '0;
                    r <= '0;
                    w <= '0;
                end
                INJECT: w <= w + 4'd1;          // wraps to 0 after word 15
                COPY_K: begin
                    s <= s + 5'd1;
                    w <= '0;
                end
                MIX:    w <= (w == 4'd7) ? 4'd0 : w + 4'd1;
                COPY_R: begin
                    r <= r_inc;
                    w <= '0;
                end
                default: ;
            endcase
        end
    end

    // Tweak words for this injection: t[s mod 3] and t[(s+1) mod 3], t2 = t0 ^ t1.
    always_comb begin
        tw_a = t0_q;
        tw_b = t1_q;
        case (s_mod3)
            2'd1:    begin tw_a = t1_q; tw_b = t2;   end
            2'd2:    begin tw_a = t2;   tw_b = t0_q; end
            default: begin tw_a = t0_q; tw_b = t1_q; end
        endcase
    end

    always_comb begin
        state_nxt                              = cur;
        bus.busy_o                             = (cur != IDLE);
        bus.hash_mode_o                        = (cur != IDLE) && !first_q;
        bus.done_o                             = 1'b0;
        bus.input_register_write_o             = 1'b0;
        bus.word_o                             = '0;
        bus.x0_key_select_o                    = 1'b0;
        bus.x1_tweak_subkey_select_o           = 2'b00;
        bus.tweak_word_o                       = '0;
        bus.rotate_constant_o                  = '0;
        bus.Y1_select_o                        = '0;
        bus.output_register_write_o            = '0;
        bus.key_register_write_o               = 1'b0;
        bus.subkey_write_o                     = 1'b0;
        bus.output_register_plaintext_select_o = 1'b0;
        bus.subkey_o                           = '0;
        bus.hash_register_write_o              = 1'b0;

        case (cur)
            IDLE: if (bus.start_i) state_nxt = LOAD;
            LOAD: begin
                bus.output_register_plaintext_select_o = 1'b1;
                bus.input_register_write_o             = 1'b1;
                state_nxt                              = INJECT;
            end
            INJECT: begin
                bus.word_o                   = w;
                bus.x1_tweak_subkey_select_o = 2'b10;
                bus.output_register_write_o  = 16'd1 << w;
                bus.subkey_o                 = s;
                if (w == 4'd13) bus.tweak_word_o = tw_a;
                if (w == 4'd14) bus.tweak_word_o = tw_b;
                if (w == 4'd15) state_nxt = (s == 5'(NUM_INJ)) ? FINAL : COPY_K;
            end
            COPY_K: begin
                bus.input_register_write_o = 1'b1;
                bus.subkey_write_o         = 1'b1;
                state_nxt                  = MIX;
            end
            MIX: begin
                // Pair p updates words 2p and 2p+1; Y1 steers the odd word.
                bus.word_o                  = w;
                bus.output_register_write_o = 16'd3 << {w[2:0], 1'b0};
                bus.Y1_select_o             = 16'd2 << {w[2:0], 1'b0};
                bus.rotate_constant_o       = ROT[{r[2:0], w[2:0]}];
                if (w == 4'd7) state_nxt = COPY_R;
            end
            COPY_R: begin
                bus.input_register_write_o = 1'b1;
                state_nxt = ((r_inc % RW'(INJ_PERIOD)) == '0) ? INJECT : MIX;
            end
            FINAL: begin
                bus.done_o                = 1'b1;
                bus.key_register_write_o  = !last_q;
                bus.hash_register_write_o = last_q;
                state_nxt                 = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_core_sequencer.sv
// Purpose: directed self-checking bench for core_sequencer (full blocks, back-to-back, reset cases).
// Latency: expects done at cycle 1078 and idle at 1079 after the start cycle.
// Backpressure: none exercised; start while busy must be ignored.
module tb_core_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    core_sequencer_if bus();

    core_sequencer #(.ROUNDS(80), .INJ_PERIOD(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    logic [123:0] all_outs;
    assign all_outs = {bus.busy_o, bus.done_o, bus.input_register_write_o, bus.word_o,
                       bus.x0_key_select_o, bus.x1_tweak_subkey_select_o, bus.tweak_word_o,
                       bus.rotate_constant_o, bus.Y1_select_o, bus.output_register_write_o,
                       bus.key_register_write_o, bus.hash_mode_o, bus.subkey_write_o,
                       bus.output_register_plaintext_select_o, bus.subkey_o,
                       bus.hash_register_write_o};

    int checks = 0;
    int errors = 0;

    int done_cnt, done_cyc, krw_cnt, hrw_cnt, skw_cnt, mix_cnt, inj_groups;
    int busy_bad, hm_bad, tw_bad, sub_bad, load_ok, krw_at_done, hrw_at_done, busy_end;
    logic [63:0] tw13 [3];
    logic [63:0] tw14 [3];
    logic [15:0] m3_orw, m3_y1;
    logic [3:0]  m3_word;
    logic [7:0]  m3_rot, m76_rot, m16_rot, m63_rot;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int c, input bit first_b);
        if (c == 1) load_ok = int'(bus.output_register_plaintext_select_o && bus.input_register_write_o);
        if (bus.done_o) begin
            done_cnt++;
            done_cyc    = c;
            krw_at_done = int'(bus.key_register_write_o);
            hrw_at_done = int'(bus.hash_register_write_o);
        end
        krw_cnt += int'(bus.key_register_write_o);
        hrw_cnt += int'(bus.hash_register_write_o);
        skw_cnt += int'(bus.subkey_write_o);
        if (bus.busy_o !== (c <= 1078)) busy_bad++;
        if (bus.hash_mode_o !== ((c <= 1078) && !first_b)) hm_bad++;
        if (bus.x1_tweak_subkey_select_o == 2'b10) begin
            if (bus.word_o == 4'd0) inj_groups++;
            if (int'(bus.subkey_o) != inj_groups - 1) sub_bad++;
            if (bus.word_o == 4'd13) begin
                if (inj_groups <= 3) tw13[inj_groups-1] = bus.tweak_word_o;
            end else if (bus.word_o == 4'd14) begin
                if (inj_groups <= 3) tw14[inj_groups-1] = bus.tweak_word_o;
            end else if (bus.tweak_word_o != 64'd0) begin
                tw_bad++;
            end
        end
        if (bus.x1_tweak_subkey_select_o == 2'b00 && bus.output_register_write_o != 16'd0) begin
            case (mix_cnt)
                3: begin
                    m3_orw  = bus.output_register_write_o;
                    m3_y1   = bus.Y1_select_o;
                    m3_rot  = bus.rotate_constant_o;
                    m3_word = bus.word_o;
                end
                16: m16_rot = bus.rotate_constant_o;
                63: m63_rot = bus.rotate_constant_o;
                76: m76_rot = bus.rotate_constant_o;
                default: ;
            endcase
            mix_cnt++;
        end
        if (c == 1079) busy_end = int'(bus.busy_o);
    endtask

    // Launches a block in the current cycle (cycle 0) and observes cycles 1..1079.
    // extra > 0 pulses start again in that (busy) cycle.
    task automatic run_block(input bit first_b, input bit last_b, input logic [127:0] tw, input int extra);
        done_cnt = 0; done_cyc = -1; krw_cnt = 0; hrw_cnt = 0; skw_cnt = 0; mix_cnt = 0;
        inj_groups = 0; busy_bad = 0; hm_bad = 0; tw_bad = 0; sub_bad = 0; load_ok = 0;
        krw_at_done = -1; hrw_at_done = -1; busy_end = -1;
        for (int i = 0; i < 3; i++) begin tw13[i] = 'x; tw14[i] = 'x; end
        bus.first_block_i = first_b;
        bus.last_block_i  = last_b;
        bus.tweak_i       = tw;
        bus.start_i       = 1'b1;
        @(posedge clk); #1;
        bus.start_i       = 1'b0;
        bus.first_block_i = !first_b;
        bus.last_block_i  = !last_b;
        bus.tweak_i       = ~tw;
        for (int c = 1; c <= 1079; c++) begin
            sample(c, first_b);
            if (c < 1079) begin
                bus.start_i = (c == extra);
                @(posedge clk); #1;
                bus.start_i = 1'b0;
            end
        end
    endtask

    task automatic check_block(input string p, input bit last_b);
        chk({p, "_load"},        128'(load_ok),     128'd1);
        chk({p, "_done_cnt"},    128'(done_cnt),    128'd1);
        chk({p, "_done_cyc"},    128'(done_cyc),    128'd1078);
        chk({p, "_krw_done"},    128'(krw_at_done), last_b ? 128'd0 : 128'd1);
        chk({p, "_hrw_done"},    128'(hrw_at_done), last_b ? 128'd1 : 128'd0);
        chk({p, "_krw_cnt"},     128'(krw_cnt),     last_b ? 128'd0 : 128'd1);
        chk({p, "_hrw_cnt"},     128'(hrw_cnt),     last_b ? 128'd1 : 128'd0);
        chk({p, "_busy_bad"},    128'(busy_bad),    128'd0);
        chk({p, "_busy_end"},    128'(busy_end),    128'd0);
        chk({p, "_hmode_bad"},   128'(hm_bad),      128'd0);
        chk({p, "_mix_cnt"},     128'(mix_cnt),     128'd640);
        chk({p, "_inj_groups"},  128'(inj_groups),  128'd21);
        chk({p, "_subkey_wr"},   128'(skw_cnt),     128'd20);
        chk({p, "_tweak_zero"},  128'(tw_bad),      128'd0);
        chk({p, "_subkey_idx"},  128'(sub_bad),     128'd0);
        chk({p, "_r0p3_orw"},    128'(m3_orw),      128'h00C0);
        chk({p, "_r0p3_y1"},     128'(m3_y1),       128'h0080);
        chk({p, "_r0p3_word"},   128'(m3_word),     128'd3);
        chk({p, "_r0p3_rot"},    128'(m3_rot),      128'd47);
        chk({p, "_r2p0_rot"},    128'(m16_rot),     128'd33);
        chk({p, "_r7p7_rot"},    128'(m63_rot),     128'd20);
        chk({p, "_r9p4_rot"},    128'(m76_rot),     128'd49);
    endtask

    initial begin
        rst               = 1'b1;
        bus.start_i       = 1'b0;
        bus.first_block_i = 1'b0;
        bus.last_block_i  = 1'b0;
        bus.tweak_i       = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", 128'(all_outs), 128'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_outs", 128'(all_outs), 128'd0);

        // First block, result to key register.
        run_block(1'b1, 1'b0, {64'hA, 64'h5}, 0);
        check_block("b1", 1'b0);
        chk("b1_s0_w13", 128'(tw13[0]), 128'h5);
        chk("b1_s0_w14", 128'(tw14[0]), 128'hA);
        chk("b1_s1_w13", 128'(tw13[1]), 128'hA);
        chk("b1_s1_w14", 128'(tw14[1]), 128'hF);
        chk("b1_s2_w13", 128'(tw13[2]), 128'hF);
        chk("b1_s2_w14", 128'(tw14[2]), 128'h5);

        // Back-to-back from cycle 1079: last block, result to hash register.
        run_block(1'b0, 1'b1, {64'h1234, 64'h00FF}, 0);
        check_block("b2", 1'b1);
        chk("b2_s1_w13", 128'(tw13[1]), 128'h1234);
        chk("b2_s1_w14", 128'(tw14[1]), 128'h12CB);
        chk("b2_s2_w13", 128'(tw13[2]), 128'h12CB);
        chk("b2_s2_w14", 128'(tw14[2]), 128'h00FF);

        // Reset at cycle 500 of a block, restart at 700, ignored start at 800.
        bus.first_block_i = 1'b0;
        bus.last_block_i  = 1'b0;
        bus.start_i       = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        for (int c = 2; c <= 500; c++) begin
            @(posedge clk); #1;
        end
        chk("mid_busy", 128'(bus.busy_o), 128'd1);
        rst = 1'b1;
        #1;
        chk("rst_cycle_outs", 128'(all_outs), 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_rst_outs", 128'(all_outs), 128'd0);
        for (int c = 502; c <= 700; c++) begin
            @(posedge clk); #1;
        end
        chk("pre_restart_idle", 128'(bus.busy_o), 128'd0);
        run_block(1'b1, 1'b1, {64'h3, 64'h1}, 100);
        check_block("b3", 1'b1);

        // Reset and start together in IDLE: reset wins.
        rst         = 1'b1;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        rst         = 1'b0;
        bus.start_i = 1'b0;
        #1;
        chk("rst_start_busy", 128'(bus.busy_o), 128'd0);
        chk("rst_start_outs", 128'(all_outs), 128'd0);
        @(posedge clk); #1;
        chk("rst_start_next", 128'(all_outs), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- FSM that drives every control input of the Skein-1024/Threefish-1024 `core` datapath to hash one 1024-bit block.
- Schedule: plaintext load, 21 subkey injections, 80 rounds of 8 MIX operations (one MIX per cycle), state copy-backs, then the final feed-forward write to the key or hash register.
- Sits between the top-level nonce/block scheduler and `core`.

Parameters:
- ROUNDS, 80, Threefish rounds per block.
- INJ_PERIOD, 4, rounds between subkey injections.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  begin a block; sampled in IDLE only
- first_block_i  in  1  block uses key constant and nonce plaintext; latched at start
- last_block_i  in  1  result goes to hash register; latched at start
- tweak_i  in  128  block tweak {t1,t0}; latched at start
- busy_o  out  1  high from the cycle after start is accepted until return to IDLE
- done_o  out  1  one-cycle pulse in the FINAL cycle
- input_register_write_o  out  1  to core input_register_write_i
- word_o  out  4  to core word_i
- x0_key_select_o  out  1  0 = state x0, 1 = key word
- x1_tweak_subkey_select_o  out  2  00 = state x1, 01 = tweak, 10 = subkey
- tweak_word_o  out  64  to core tweak_word_i
- rotate_constant_o  out  8  to core rotate_constant_i
- Y1_select_o  out  16  to core Y1_select_i
- output_register_write_o  out  16  to core output_register_write_i
- key_register_write_o  out  1  to core key_register_write_i
- hash_mode_o  out  1  0 on first block, else 1
- subkey_write_o  out  1  to core subkey_write_i
- output_register_plaintext_select_o  out  1  1 = plaintext, 0 = output register
- subkey_o  out  5  current subkey index s
- hash_register_write_o  out  1  to core hash_register_write_i

Behaviour:

Reset and defaults
- Reset wins over every other input.
- Reset returns the FSM to IDLE and clears all counters and latches.
- All outputs are 0 during and after reset, including mid-block. No write enable may be high in the reset cycle.

Sequencing
- start_i while busy is ignored.
- Counters:
  - s: subkey index, 0..20.
  - r: round, 0..ROUNDS-1.
  - w: cycle within a group, 0..15 for INJECT, 0..7 for MIX.

States
- IDLE
  - All enables 0.
  - start_i=1: latch first_block_i, last_block_i and tweak_i; go to LOAD.
- LOAD (1 cycle)
  - output_register_plaintext_select_o=1, input_register_write_o=1.
  - s=0; go to INJECT.
- INJECT (16 cycles, word_o=w)
  - x0_key_select_o=0, x1_tweak_subkey_select_o=10, Y1_select_o=0, output_register_write_o=1<<w, subkey_o=s.
  - tweak_word_o = t[s mod 3] at w=13, t[(s+1) mod 3] at w=14, 0 otherwise, where t2 = t0^t1.
  - After w=15: go to FINAL if s=20, else to COPY_K.
- COPY_K (1 cycle)
  - input_register_write_o=1, output_register_plaintext_select_o=0, subkey_write_o=1.
  - s increments; go to MIX.
- MIX (8 cycles, pair p=w, word_o=p)
  - x0_key_select_o=0, x1_tweak_subkey_select_o=00.
  - output_register_write_o = bits 2p and 2p+1 set.
  - Y1_select_o = bit 2p+1 set.
  - rotate_constant_o = R[r mod 8][p], the standard Threefish-1024 rotation table held as constants. Row 0 = 24,13,8,47,8,17,22,37; row 1 = 38,19,10,55,49,18,23,52.
  - After p=7: go to COPY_R.
- COPY_R (1 cycle)
  - input_register_write_o=1, output_register_plaintext_select_o=0.
  - r increments.
  - If the new r mod INJ_PERIOD = 0, go to INJECT; else go to MIX.
- FINAL (1 cycle)
  - done_o=1.
  - key_register_write_o = ~last_block; hash_register_write_o = last_block.
  - Go to IDLE.

Outputs and timing
- hash_mode_o = ~first_block latch, held constant while busy, 0 in IDLE.
- All outputs are registered, or decoded only from state and counters, so they are glitch-free relative to clk_i.
- Latency with the start edge at cycle 0:
  - LOAD at cycle 1.
  - 20 × (16+1+4×9) = 1060 cycles.
  - INJECT s=20 at cycles 1062–1077.
  - FINAL at cycle 1078.
  - IDLE at cycle 1079, with busy_o=0.
- Back-to-back: start_i held high in cycle 1079 launches the next block, so there are no idle bubbles beyond that one cycle.

Test Plan:
1. Reset, then start_i=1 for one cycle with first_block_i=1, last_block_i=0 -> LOAD at cycle 1 with plaintext_select=1. done_o at cycle 1078 only. key_register_write_o=1 and hash_register_write_o=0 at cycle 1078. busy_o=0 at cycle 1079. hash_mode_o=0 throughout.
2. Same start with last_block_i=1, first_block_i=0 -> hash_register_write_o=1 at cycle 1078, key_register_write_o never high, hash_mode_o=1 while busy.
3. Monitor MIX cycles -> round 0, pair 3: output_register_write_o=16'h00C0, Y1_select_o=16'h0080, rotate_constant_o=47. Round 9, pair 4: rotate_constant_o=49. Exactly 640 MIX cycles and 21 INJECT groups.
4. tweak_i={64'hA,64'h5}, s=1 -> w=13: tweak_word_o=64'hA; w=14: tweak_word_o=64'hF; other words 0. subkey_write_o pulses 20 times per block.
5. Assert rst_i at cycle 500 -> next cycle all outputs 0, IDLE. start_i pulsed at cycle 700 while busy is not asserted before that -> a full 1078-cycle block. start_i pulsed at cycle 800 (busy) -> ignored.
6. rst_i and start_i both high in the same IDLE cycle -> stays IDLE, busy_o=0.
